// File: rtl/mem_dbus.sv
// mem_dbus: memory-access stage between the EX/MEM and MEM/WB registers.
// Non-memory instructions pass straight through. Loads, stores, LL and SC run
// a request/acknowledge transaction on the data bus, and the stage holds the
// pipeline through stallreq_o until the bus acknowledges. The stage owns the
// LL/SC link bit and performs big-endian byte-lane steering and load extension.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wd_i/wreg_i/wdata_i destination, write enable and ALU result from EX/MEM
//   whilo_i/hi_i/lo_i   HI/LO write-back, passed through
//   aluop_i             operation code
//   mem_addr_i, reg2_i  effective address and store data
//   hold_i, flush_i     MEM/WB stall and exception flush
//   wd_o..lo_o          results towards MEM/WB
//   stallreq_o          pipeline stall request
//   align_err_o         misaligned access flag
//   llbit_o             current link bit
//   dbus_*              data-bus master interface (sel bit 3 = byte address 0)
module mem_dbus #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              whilo_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic [7:0]        aluop_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic              hold_i,
   input  logic              flush_i,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              whilo_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              stallreq_o,
   output logic              align_err_o,
   output logic              llbit_o,
   output logic [ADDR_W-1:0] dbus_addr_o,
   output logic [DATA_W-1:0] dbus_data_o,
   output logic [3:0]        dbus_sel_o,
   output logic              dbus_we_o,
   output logic              dbus_stb_o,
   input  logic [DATA_W-1:0] dbus_data_i,
   input  logic              dbus_ack_i
);

   localparam logic [7:0] OpLb  = 8'b1110_0000;
   localparam logic [7:0] OpLbu = 8'b1110_0100;
   localparam logic [7:0] OpLh  = 8'b1110_0001;
   localparam logic [7:0] OpLhu = 8'b1110_0101;
   localparam logic [7:0] OpLw  = 8'b1110_0011;
   localparam logic [7:0] OpSb  = 8'b1110_1000;
   localparam logic [7:0] OpSh  = 8'b1110_1001;
   localparam logic [7:0] OpSw  = 8'b1110_1011;
   localparam logic [7:0] OpLl  = 8'b1111_0000;
   localparam logic [7:0] OpSc  = 8'b1111_1000;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic              llbit_q, llbit_d;
   logic              stb_q, we_q;
   logic [3:0]        sel_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdat_q;
   logic [DATA_W-1:0] rdata_q;
   logic [7:0]        op_q;
   logic [1:0]        alo_q;
   logic              flushed_q;

   logic              is_load, is_store, is_half, is_word, is_mem;
   logic              misalign, sc_fail, start, done_exit;
   logic [3:0]        st_sel;
   logic [DATA_W-1:0] st_data;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] load_res;

   // Decode of the incoming instruction.
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (aluop_i)
         OpLb, OpLbu: is_load = 1'b1;
         OpLh, OpLhu: begin
            is_load = 1'b1;
            is_half = 1'b1;
         end
         OpLw, OpLl: begin
            is_load = 1'b1;
            is_word = 1'b1;
         end
         OpSb: is_store = 1'b1;
         OpSh: begin
            is_store = 1'b1;
            is_half  = 1'b1;
         end
         OpSw, OpSc: begin
            is_store = 1'b1;
            is_word  = 1'b1;
         end
         default: ;
      endcase
   end

   assign is_mem   = is_load | is_store;
   assign misalign = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
   // An SC without a valid link completes immediately as a failed store.
   assign sc_fail  = (aluop_i == OpSc) & ~llbit_q;
   assign start    = (state_q == StIdle) & is_mem & ~misalign & ~sc_fail & ~flush_i;

   // Big-endian byte-lane steering for stores; loads read the whole word.
   always_comb begin
      st_sel  = 4'b1111;
      st_data = reg2_i;
      case (aluop_i)
         OpSb: begin
            st_sel  = 4'b1000 >> mem_addr_i[1:0];
            st_data = {4{reg2_i[7:0]}};
         end
         OpSh: begin
            st_sel  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            st_data = {2{reg2_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction from the captured bus word.
   always_comb begin
      case (alo_q)
         2'd0:    ld_byte = rdata_q[31:24];
         2'd1:    ld_byte = rdata_q[23:16];
         2'd2:    ld_byte = rdata_q[15:8];
         default: ld_byte = rdata_q[7:0];
      endcase
      ld_half = alo_q[1] ? rdata_q[15:0] : rdata_q[31:16];
      case (op_q)
         OpLb:    load_res = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         OpLbu:   load_res = {{(DATA_W-8){1'b0}}, ld_byte};
         OpLh:    load_res = {{(DATA_W-16){ld_half[15]}}, ld_half};
         OpLhu:   load_res = {{(DATA_W-16){1'b0}}, ld_half};
         default: load_res = rdata_q;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (start) state_d = StBusy;
         StBusy: if (dbus_ack_i) state_d = StDone;
         StDone: begin
            // A flushed transaction never waits on hold: its result is discarded.
            if (flush_i || flushed_q || !hold_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign done_exit = (state_q == StDone) & (state_d == StIdle);

   // Link bit: updated when an LL/SC leaves DONE; flush wins over everything.
   always_comb begin
      llbit_d = llbit_q;
      if (done_exit && !flushed_q) begin
         if (op_q == OpLl) begin
            llbit_d = 1'b1;
         end else if (op_q == OpSc) begin
            llbit_d = 1'b0;
         end
      end
      if (flush_i) llbit_d = 1'b0;
   end

   // Bus request registers and transaction context.
   always_ff @(posedge clk) begin
      if (rst) begin
         llbit_q   <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 4'b0000;
         addr_q    <= '0;
         wdat_q    <= '0;
         rdata_q   <= '0;
         op_q      <= 8'h00;
         alo_q     <= 2'b00;
         flushed_q <= 1'b0;
      end else begin
         llbit_q <= llbit_d;
         case (state_q)
            StIdle: begin
               if (start) begin
                  addr_q    <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                  wdat_q    <= st_data;
                  sel_q     <= st_sel;
                  we_q      <= is_store;
                  stb_q     <= 1'b1;
                  op_q      <= aluop_i;
                  alo_q     <= mem_addr_i[1:0];
                  flushed_q <= 1'b0;
               end
            end
            StBusy: begin
               if (flush_i) flushed_q <= 1'b1;
               if (dbus_ack_i) begin
                  rdata_q <= dbus_data_i;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // FSM outputs towards the pipeline.
   always_comb begin
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      whilo_o     = whilo_i;
      hi_o        = hi_i;
      lo_o        = lo_i;
      stallreq_o  = 1'b0;
      align_err_o = 1'b0;
      if (rst) begin
         wd_o    = 5'd0;
         wreg_o  = 1'b0;
         wdata_o = '0;
         whilo_o = 1'b0;
         hi_o    = '0;
         lo_o    = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (is_mem) begin
                  if (misalign) begin
                     align_err_o = 1'b1;
                     wreg_o      = 1'b0;
                  end else if (sc_fail) begin
                     wdata_o = '0;
                     wreg_o  = 1'b1;
                  end else begin
                     stallreq_o = ~flush_i;
                     wreg_o     = 1'b0;
                  end
               end
            end
            StBusy: begin
               stallreq_o = 1'b1;
               wreg_o     = 1'b0;
            end
            StDone: begin
               if (flushed_q) begin
                  wreg_o = 1'b0;
               end else begin
                  case (op_q)
                     OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLl: begin
                        wdata_o = load_res;
                        wreg_o  = wreg_i;
                     end
                     OpSc: begin
                        wdata_o = {{(DATA_W-1){1'b0}}, 1'b1};
                        wreg_o  = 1'b1;
                     end
                     default: wreg_o = 1'b0;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign llbit_o     = llbit_q;
   assign dbus_addr_o = addr_q;
   assign dbus_data_o = wdat_q;
   assign dbus_sel_o  = sel_q;
   assign dbus_we_o   = we_q;
   assign dbus_stb_o  = stb_q;

endmodule
